// File: rtl/vga_pkg.sv
// Shared colour, channel and fade definitions for the emblem overlay path.
package vga_pkg;

   // 6-bit colour words are packed {R1,G1,B1,R0,G0,B0}
   localparam logic [5:0] COLOR_TRANSPARENT = 6'b100001;
   localparam logic [5:0] COLOR_BLACK       = 6'b000000;

   // Bit positions of each channel's high and low bit inside a colour word
   localparam int R1_BIT = 5;
   localparam int G1_BIT = 4;
   localparam int B1_BIT = 3;
   localparam int R0_BIT = 2;
   localparam int G0_BIT = 1;
   localparam int B0_BIT = 0;

   // Fully faded-in blend level; levels run 0..FADE_MAX
   localparam logic [2:0] FADE_MAX = 3'd4;

   typedef enum logic [1:0] {
      HIDDEN   = 2'd0,
      FADE_IN  = 2'd1,
      SHOWN    = 2'd2,
      FADE_OUT = 2'd3
   } fade_state_t;

   // One 2-bit channel: (e*L + b*(4-L)) >> 2, all terms fit in 4 bits (max 12)
   function automatic logic [1:0] blend_chan(input logic [1:0] e,
                                             input logic [1:0] b,
                                             input logic [2:0] lvl);
      logic [3:0] sum;
      sum = ({2'b00, e} * {1'b0, lvl}) + ({2'b00, b} * ({1'b0, FADE_MAX} - {1'b0, lvl}));
      return sum[3:2];
   endfunction

endpackage

// File: rtl/fade_ctrl.sv
// Frame-driven fade controller: detects the start of each vsync pulse,
// counts frames between level steps and walks the blend level 0..4.
module fade_ctrl
   import vga_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 8,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic       show,
   output logic [2:0] fade_level,
   output logic       fading
);

   localparam logic       VS_ASSERTED = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam logic [7:0] CNT_LAST    = 8'(FRAMES_PER_STEP - 1);

   logic        vsync_prev;
   logic        frame_tick;
   logic        step_tick;
   logic [7:0]  frame_cnt;
   fade_state_t state;
   fade_state_t state_next;
   logic [2:0]  level_next;
   logic        fading_next;

   // A frame begins when the stage-1 vsync enters its asserted level
   assign frame_tick = (vsync == VS_ASSERTED) && (vsync_prev != VS_ASSERTED);
   assign step_tick  = frame_tick && (frame_cnt == CNT_LAST);

   // Vsync history starts deasserted so reset release cannot fake a frame start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_prev <= ~VS_ASSERTED;
      end else begin
         vsync_prev <= vsync;
      end
   end

   // Frame counter free-runs across direction changes and wraps on the step tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= 8'd0;
      end else if (step_tick) begin
         frame_cnt <= 8'd0;
      end else if (frame_tick) begin
         frame_cnt <= frame_cnt + 8'd1;
      end else begin
         frame_cnt <= frame_cnt;
      end
   end

   // Next state and level: a show change wins over a pending step, level saturates at 0 and 4
   always_comb begin
      state_next = state;
      level_next = fade_level;
      case (state)
         HIDDEN: begin
            if (show) begin
               state_next = FADE_IN;
            end else begin
               state_next = HIDDEN;
            end
         end
         FADE_IN: begin
            if (!show) begin
               state_next = FADE_OUT;
            end else if (fade_level >= FADE_MAX) begin
               state_next = SHOWN;
            end else if (step_tick) begin
               level_next = fade_level + 3'd1;
               if (fade_level == (FADE_MAX - 3'd1)) begin
                  state_next = SHOWN;
               end else begin
                  state_next = FADE_IN;
               end
            end else begin
               state_next = FADE_IN;
            end
         end
         SHOWN: begin
            if (!show) begin
               state_next = FADE_OUT;
            end else begin
               state_next = SHOWN;
            end
         end
         FADE_OUT: begin
            if (show) begin
               state_next = FADE_IN;
            end else if (fade_level == 3'd0) begin
               state_next = HIDDEN;
            end else if (step_tick) begin
               level_next = fade_level - 3'd1;
               if (fade_level == 3'd1) begin
                  state_next = HIDDEN;
               end else begin
                  state_next = FADE_OUT;
               end
            end else begin
               state_next = FADE_OUT;
            end
         end
         default: begin
            state_next = HIDDEN;
            level_next = 3'd0;
         end
      endcase
      fading_next = (state_next == FADE_IN) || (state_next == FADE_OUT);
   end

   // State, level and fading flag are all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HIDDEN;
         fade_level <= 3'd0;
         fading     <= 1'b0;
      end else begin
         state      <= state_next;
         fade_level <= level_next;
         fading     <= fading_next;
      end
   end

endmodule

// File: rtl/overlay_mixer.sv
// Two-stage compositor: registers the pixel inputs, keys and blends the emblem
// over the background at the current fade level, blanks and packs for TinyVGA.
module overlay_mixer
   import vga_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 8,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       active,
   input  logic [5:0] emblem_rgb,
   input  logic [5:0] bg_rgb,
   input  logic       show,
   output logic [7:0] uo_out,
   output logic [2:0] fade_level,
   output logic       fading
);

   localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

   logic       hsync_s1;
   logic       vsync_s1;
   logic       active_s1;
   logic [5:0] emblem_s1;
   logic [5:0] bg_s1;

   logic [5:0] key_rgb;
   logic [1:0] r_mix;
   logic [1:0] g_mix;
   logic [1:0] b_mix;
   logic [5:0] pix;

   // Stage 1: capture every pixel-aligned input together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_s1  <= SYNC_IDLE;
         vsync_s1  <= SYNC_IDLE;
         active_s1 <= 1'b0;
         emblem_s1 <= COLOR_BLACK;
         bg_s1     <= COLOR_BLACK;
      end else begin
         hsync_s1  <= hsync;
         vsync_s1  <= vsync;
         active_s1 <= active;
         emblem_s1 <= emblem_rgb;
         bg_s1     <= bg_rgb;
      end
   end

   fade_ctrl #(
      .FRAMES_PER_STEP (FRAMES_PER_STEP),
      .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_fade_ctrl (
      .clk        (clk),
      .rst        (rst),
      .vsync      (vsync_s1),
      .show       (show),
      .fade_level (fade_level),
      .fading     (fading)
   );

   // Key out the transparent code by substituting the background, then blend and blank
   always_comb begin
      if (emblem_s1 == COLOR_TRANSPARENT) begin
         key_rgb = bg_s1;
      end else begin
         key_rgb = emblem_s1;
      end
      r_mix = blend_chan({key_rgb[R1_BIT], key_rgb[R0_BIT]}, {bg_s1[R1_BIT], bg_s1[R0_BIT]}, fade_level);
      g_mix = blend_chan({key_rgb[G1_BIT], key_rgb[G0_BIT]}, {bg_s1[G1_BIT], bg_s1[G0_BIT]}, fade_level);
      b_mix = blend_chan({key_rgb[B1_BIT], key_rgb[B0_BIT]}, {bg_s1[B1_BIT], bg_s1[B0_BIT]}, fade_level);
      if (active_s1) begin
         pix = {r_mix[1], g_mix[1], b_mix[1], r_mix[0], g_mix[0], b_mix[0]};
      end else begin
         pix = COLOR_BLACK;
      end
   end

   // Stage 2: pack colour and delay-matched syncs in PMOD order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uo_out <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
      end else begin
         uo_out <= {hsync_s1, pix[B0_BIT], pix[G0_BIT], pix[R0_BIT],
                    vsync_s1, pix[B1_BIT], pix[G1_BIT], pix[R1_BIT]};
      end
   end

endmodule

// File: tb/tb_overlay_mixer.sv
// Self-checking bench for overlay_mixer: table-driven blend vectors through a
// 2-deep scoreboard, plus frame sequences for fade stepping and async reset.
module tb_overlay_mixer;

   localparam int S_HID   = 0;
   localparam int S_IN    = 1;
   localparam int S_SHOWN = 2;
   localparam int S_OUT   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       hsync;
   logic       vsync;
   logic       active;
   logic [5:0] emblem_rgb;
   logic [5:0] bg_rgb;
   logic       show;
   logic [7:0] uo_out;
   logic [2:0] fade_level;
   logic       fading;

   typedef struct {
      logic       valid;
      logic [7:0] uo;
   } exp_t;

   typedef struct {
      logic [2:0] lvl;
      logic       hs;
      logic       act;
      logic [5:0] e;
      logic [5:0] b;
      logic [5:0] col;
   } vec_t;

   exp_t       exp_q[$];
   vec_t       vecs[17];
   logic [5:0] lvl_col[5];
   int         n_vec  = 0;
   int         n_miss = 0;
   int         exp_l;
   int         exp_st;
   int         tick_cnt;

   always #5 clk = ~clk;

   overlay_mixer #(
      .FRAMES_PER_STEP (2),
      .SYNC_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .hsync      (hsync),
      .vsync      (vsync),
      .active     (active),
      .emblem_rgb (emblem_rgb),
      .bg_rgb     (bg_rgb),
      .show       (show),
      .uo_out     (uo_out),
      .fade_level (fade_level),
      .fading     (fading)
   );

   function automatic logic [7:0] pack(input logic hs, input logic vs, input logic [5:0] c);
      return {hs, c[0], c[1], c[2], vs, c[3], c[4], c[5]};
   endfunction

   function automatic logic exp_fading();
      return (exp_st == S_IN) || (exp_st == S_OUT);
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %b, expected %b", name, got, want);
      end
   endtask

   task automatic check_fsm(input string tag);
      check({tag, ".fade_level"}, {5'b00000, fade_level}, 8'(exp_l));
      check({tag, ".fading"}, {7'b0000000, fading}, {7'b0000000, exp_fading()});
   endtask

   // Output seen now belongs to the input driven two calls earlier
   task automatic apply(input logic hs, input logic vs, input logic act,
                        input logic [5:0] e, input logic [5:0] b,
                        input logic v, input logic [7:0] want);
      exp_t item;
      exp_t nitem;
      if (exp_q.size() >= 2) begin
         item = exp_q.pop_front();
         if (item.valid) check("uo_out", uo_out, item.uo);
      end
      hsync      = hs;
      vsync      = vs;
      active     = act;
      emblem_rgb = e;
      bg_rgb     = b;
      nitem.valid = v;
      nitem.uo    = want;
      exp_q.push_back(nitem);
      @(posedge clk);
      #1;
   endtask

   task automatic model_step();
      if (exp_st == S_IN) begin
         exp_l++;
         if (exp_l == 4) exp_st = S_SHOWN;
      end else if (exp_st == S_OUT) begin
         exp_l--;
         if (exp_l == 0) exp_st = S_HID;
      end
   endtask

   // Mini frame: 2 blanked vsync cycles then 3 active pixels of emblem 110110 over black
   task automatic frame();
      apply(1'b1, 1'b0, 1'b0, 6'b110110, 6'b000000, 1'b1, pack(1'b1, 1'b0, 6'b000000));
      apply(1'b1, 1'b0, 1'b0, 6'b110110, 6'b000000, 1'b1, pack(1'b1, 1'b0, 6'b000000));
      if (tick_cnt == 1) begin
         tick_cnt = 0;
         model_step();
      end else begin
         tick_cnt = tick_cnt + 1;
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b1, 1'b1, 6'b110110, 6'b000000, 1'b1, pack(1'b1, 1'b1, lvl_col[exp_l]));
      end
      check_fsm("frame");
   endtask

   task automatic fade_to(input int target);
      int g;
      g = 0;
      while (exp_l != target && g < 40) begin
         frame();
         g++;
      end
   endtask

   task automatic set_show(input logic v);
      show = v;
      apply(1'b1, 1'b1, 1'b1, 6'b110110, 6'b000000, 1'b1, pack(1'b1, 1'b1, lvl_col[exp_l]));
      if (v && (exp_st == S_HID || exp_st == S_OUT)) exp_st = S_IN;
      if (!v && (exp_st == S_SHOWN || exp_st == S_IN)) exp_st = S_OUT;
      check_fsm("show");
   endtask

   task automatic run_table(input logic [2:0] lvl);
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].lvl == lvl) begin
            apply(vecs[i].hs, 1'b1, vecs[i].act, vecs[i].e, vecs[i].b, 1'b1,
                  pack(vecs[i].hs, 1'b1, vecs[i].col));
         end
      end
   endtask

   initial begin
      // {level, hsync, active, emblem, bg, expected colour}
      vecs[0]  = '{3'd0, 1'b1, 1'b1, 6'b111111, 6'b101010, 6'b101010};
      vecs[1]  = '{3'd0, 1'b1, 1'b1, 6'b100001, 6'b010101, 6'b010101};
      vecs[2]  = '{3'd1, 1'b1, 1'b1, 6'b111111, 6'b000000, 6'b000000};
      vecs[3]  = '{3'd1, 1'b1, 1'b1, 6'b000000, 6'b111111, 6'b111000};
      vecs[4]  = '{3'd1, 1'b1, 1'b1, 6'b111111, 6'b010101, 6'b010101};
      vecs[5]  = '{3'd2, 1'b1, 1'b1, 6'b111111, 6'b000000, 6'b000111};
      vecs[6]  = '{3'd2, 1'b1, 1'b1, 6'b100001, 6'b101010, 6'b101010};
      vecs[7]  = '{3'd2, 1'b1, 1'b1, 6'b111111, 6'b111111, 6'b111111};
      vecs[8]  = '{3'd2, 1'b1, 1'b1, 6'b000000, 6'b111111, 6'b000111};
      vecs[9]  = '{3'd3, 1'b1, 1'b1, 6'b111111, 6'b000000, 6'b111000};
      vecs[10] = '{3'd3, 1'b1, 1'b1, 6'b010101, 6'b101010, 6'b000111};
      vecs[11] = '{3'd3, 1'b1, 1'b1, 6'b000000, 6'b111111, 6'b000000};
      vecs[12] = '{3'd4, 1'b1, 1'b1, 6'b100001, 6'b111111, 6'b111111};
      vecs[13] = '{3'd4, 1'b1, 1'b1, 6'b101010, 6'b010101, 6'b101010};
      vecs[14] = '{3'd4, 1'b0, 1'b0, 6'b111111, 6'b111111, 6'b000000};
      vecs[15] = '{3'd4, 1'b1, 1'b1, 6'b000000, 6'b111111, 6'b000000};
      vecs[16] = '{3'd4, 1'b1, 1'b1, 6'b100001, 6'b000000, 6'b000000};
      // Emblem 110110 over black at each level
      lvl_col[0] = 6'b000000;
      lvl_col[1] = 6'b000000;
      lvl_col[2] = 6'b000110;
      lvl_col[3] = 6'b110000;
      lvl_col[4] = 6'b110110;

      rst        = 1'b1;
      show       = 1'b0;
      hsync      = 1'b1;
      vsync      = 1'b1;
      active     = 1'b1;
      emblem_rgb = 6'b110110;
      bg_rgb     = 6'b000000;
      exp_l      = 0;
      exp_st     = S_HID;
      tick_cnt   = 0;

      repeat (3) @(posedge clk);
      #1;
      check("reset.uo_out", uo_out, 8'b1000_1000);
      check_fsm("reset");
      rst = 1'b0;

      // Hidden: three frames stay black, then level-0 vectors
      repeat (3) frame();
      run_table(3'd0);

      // Fade in, exercising the blend table at every level
      set_show(1'b1);
      for (int l = 1; l <= 4; l++) begin
         fade_to(l);
         run_table(3'(l));
      end

      // Full fade out
      set_show(1'b0);
      fade_to(0);

      // Reverse mid-fade at level 2
      set_show(1'b1);
      fade_to(2);
      set_show(1'b0);
      fade_to(0);

      // Asynchronous reset at level 3, between clock edges
      set_show(1'b1);
      fade_to(3);
      #3;
      check("pre_rst.uo_out", uo_out, pack(1'b1, 1'b1, 6'b110000));
      rst = 1'b1;
      #1;
      exp_l    = 0;
      exp_st   = S_HID;
      tick_cnt = 0;
      check("async_rst.uo_out", uo_out, 8'b1000_1000);
      check_fsm("async_rst");
      exp_q.delete();
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_st = S_IN;
      check_fsm("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/overlay_mixer.md
# overlay_mixer

Registered compositor between the emblem pixel generator and the TinyVGA output pins. Each cycle it takes the emblem's 6-bit colour and a background colour for the same pixel. It keys out the transparent code, blends the emblem over the background at a frame-stepped fade level, blanks outside the active area and packs the result with delay-matched syncs onto `uo_out`. A small frame-driven FSM fades the emblem in or out when the `show` request changes.

## Interface
- `FRAMES_PER_STEP`, 8: frames between fade-level steps (1..255).
- `SYNC_ACTIVE_LOW`, 1: sync polarity; 1 means a sync pulse is a low level.
- `clk` input 1: pixel clock.
- `rst` input 1: reset; asynchronous, active-high.
- `hsync`, `vsync` input 1: raw syncs from the timing generator, pixel-aligned with `emblem_rgb`.
- `active` input 1: visible-area flag, same alignment.
- `emblem_rgb` input 6: emblem colour `{R1,G1,B1,R0,G0,B0}`; `6'b100001` means transparent.
- `bg_rgb` input 6: background colour, same format.
- `show` input 1: level request; 1 fades the emblem in, 0 fades it out.
- `uo_out` output 8: `{hsync,B0,G0,R0,vsync,B1,G1,R1}` (TinyVGA PMOD order).
- `fade_level` output 3: current blend level, 0..4.
- `fading` output 1: high while in FADE_IN or FADE_OUT.

## Operation
- Channel decode: R = `{c[5],c[2]}`, G = `{c[4],c[1]}`, B = `{c[3],c[0]}`. Each channel is 0..3.
- Key: if `emblem_rgb == 6'b100001`, the emblem channels are replaced by the background channels, so output = bg at every level.
- Blend per channel: `out = (e*L + b*(4-L)) >> 2`.
  - Unsigned arithmetic; products and the sum are 4 bits wide (maximum 12).
  - L = `fade_level`. L=0 gives bg exactly; L=4 gives emblem exactly.
- Blanking: if the pipelined `active` is 0, all six colour bits are 0. Syncs still pass through.
- Frame tick: one-cycle pulse when the stage-1 registered vsync enters its asserted level. "Asserted" is low if `SYNC_ACTIVE_LOW`, high otherwise.
- Frame counter: counts frame ticks 0..FRAMES_PER_STEP-1. It wraps on the tick that reaches FRAMES_PER_STEP-1, and that tick is a step tick.
- FSM states: HIDDEN (L=0), FADE_IN, SHOWN (L=4), FADE_OUT.
  - HIDDEN → FADE_IN when `show`=1. SHOWN → FADE_OUT when `show`=0. Both evaluated every cycle.
  - FADE_IN: L increments on each step tick. When L reaches 4, go to SHOWN. If `show`=0, go to FADE_OUT immediately with L unchanged.
  - FADE_OUT: L decrements on each step tick. When L reaches 0, go to HIDDEN. If `show`=1, go to FADE_IN immediately with L unchanged.
  - The frame counter is not reset on a direction change.
- L saturates at 0 and 4; it is never stepped past either end.

## Timing
- Two-stage pipeline:
  - Stage 1 registers all pixel inputs.
  - Stage 2 registers the blended, packed `uo_out`.
- Latency: input to `uo_out` is exactly 2 cycles for colour, hsync, vsync and active alike.
- The blend uses L as registered at stage 2. An L change takes effect on the first stage-2 pixel after the step tick, within the sync pulse, so it never shows mid-frame.
- `fade_level` and `fading` are registered FSM outputs. They update 1 cycle after the cycle in which the step tick or the `show` change is sampled.
- Reset values:
  - `uo_out` colour bits = 0; sync bits = deasserted (1 when `SYNC_ACTIVE_LOW`).
  - State HIDDEN, `fade_level`=0, `fading`=0, frame counter 0.
  - Stage-1 vsync history = deasserted, so no spurious tick after reset.
- `rst` asserted mid-fade forces HIDDEN/L=0 immediately, asynchronously. After release the FSM re-evaluates `show` on the first clock edge.

## Structure
- Package `vga_pkg`:
  - `COLOR_TRANSPARENT`, `COLOR_BLACK`.
  - Channel bit-index constants.
  - `fade_state_t` enum {HIDDEN, FADE_IN, SHOWN, FADE_OUT}.
  - `FADE_MAX` = 4.
- Sub-module `fade_ctrl`: frame-tick detector, frame counter, FSM, L register. It outputs `fade_level` and `fading`.
- The top level holds the pipeline registers, the key/blend datapath and the output packing.

## Test plan
- Reset release with `show`=0, `active`=1, emblem `6'b110110`, bg `6'b000000` → `uo_out` colour 0, `fade_level`=0, syncs deasserted, across 3 frames.
- `show`=1, FRAMES_PER_STEP=2, same colours → L steps 1,2,3,4, one step per 2 frames, and `fading` clears at 4.
  - At L=2 the red channel is (3*2+0*2)>>2 = 1.
  - At L=4 `uo_out` R1=R0=G1=G0=1.
- Transparent `6'b100001` over bg `6'b111111`, L=4 → output `6'b111111` repacked as `uo_out`=`8'b0111_0111` plus sync bits.
- `active`=0 with any colour → colour bits 0 exactly 2 cycles later; an hsync pulse is seen on `uo_out[7]` with the same 2-cycle delay.
- In FADE_IN at L=2, drop `show` → state FADE_OUT next cycle, L=2 held, then 1 and 0 on the following step ticks, ending in HIDDEN.
- Assert `rst` while L=3 → `fade_level`=0 and colour bits 0 without waiting for a clock edge.
